// File: rtl/unified_mem_v2_pkg.sv
// unified_mem_v2_pkg: shared defaults and FSM encoding for the lab CPU memory.
// Holds the default data/address widths and the clear-engine state encoding.
package unified_mem_v2_pkg;

   localparam int DWIDTH_DAT = 16;
   localparam int AWIDTH_MEM = 8;

   typedef enum logic {
      MEM_ST_IDLE  = 1'b0,
      MEM_ST_CLEAR = 1'b1
   } mem_state_t;

endpackage

// File: rtl/unified_mem_v2_if.sv
// unified_mem_v2_if: user-side bus of the unified instruction/data memory.
// The debug window signal mem_out exists only when MEM_DBG_WINDOW_EN is defined.
interface unified_mem_v2_if
   import unified_mem_v2_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DAT,
   parameter int AWIDTH = AWIDTH_MEM
`ifdef MEM_DBG_WINDOW_EN
   , parameter int DBG_WORDS = 12
`endif
);

   logic              wen;
   logic [AWIDTH-1:0] waddr;
   logic [DWIDTH-1:0] din;
   logic [AWIDTH-1:0] raddr_i;
   logic [DWIDTH-1:0] iout;
   logic [AWIDTH-1:0] raddr_d;
   logic [DWIDTH-1:0] dout;
   logic              busy;
   logic              oob_err;
`ifdef MEM_DBG_WINDOW_EN
   logic [DBG_WORDS*DWIDTH-1:0] mem_out;
`endif

   modport master (
      output wen, waddr, din, raddr_i, raddr_d,
      input  iout, dout, busy, oob_err
`ifdef MEM_DBG_WINDOW_EN
      , input mem_out
`endif
   );

   modport slave (
      input  wen, waddr, din, raddr_i, raddr_d,
      output iout, dout, busy, oob_err
`ifdef MEM_DBG_WINDOW_EN
      , output mem_out
`endif
   );

endinterface

// File: rtl/unified_mem_v2_clear_ctrl.sv
// mem_clear_ctrl: reset-triggered sweep that zeroes the array one word per edge.
// busy is high for the whole sweep; clr_we/clr_addr drive the array write mux.
module mem_clear_ctrl
   import unified_mem_v2_pkg::*;
#(
   parameter int AWIDTH = AWIDTH_MEM,
   parameter int DEPTH  = 2**AWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   output logic              clr_we,
   output logic [AWIDTH-1:0] clr_addr,
   output logic              busy
);

   localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
   localparam logic [AWIDTH-1:0] ONE       = {{(AWIDTH-1){1'b0}}, 1'b1};

   mem_state_t        state_r;
   logic [AWIDTH-1:0] clr_cnt_r;
   logic              busy_r;

   // Sweep FSM: rst (re)starts at word 0, the edge that clears the last word returns to idle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= MEM_ST_CLEAR;
         clr_cnt_r <= {AWIDTH{1'b0}};
         busy_r    <= 1'b1;
      end else begin
         case (state_r)
            MEM_ST_IDLE: begin
               state_r <= MEM_ST_IDLE;
               busy_r  <= 1'b0;
            end
            MEM_ST_CLEAR: begin
               clr_cnt_r <= clr_cnt_r + ONE;
               if (clr_cnt_r == LAST_ADDR) begin
                  state_r <= MEM_ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= MEM_ST_CLEAR;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= MEM_ST_IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign clr_we   = busy_r;
   assign clr_addr = clr_cnt_r;

endmodule

// File: rtl/unified_mem_v2.sv
// unified_mem_v2: single-clock instruction/data memory, one sync write port,
// two combinational read ports with write-through bypass, sticky range error.
// Optional debug window: define MEM_DBG_WINDOW_EN to export mem_out.
module unified_mem_v2
   import unified_mem_v2_pkg::*;
#(
   parameter int DWIDTH    = DWIDTH_DAT,
   parameter int AWIDTH    = AWIDTH_MEM,
   parameter int DEPTH     = 2**AWIDTH,
   parameter int DBG_BASE  = 30,
   parameter int DBG_WORDS = 12
) (
   input  logic             clk,
   input  logic             rst,
   unified_mem_v2_if.slave  bus
);

   localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

   logic [DWIDTH-1:0] mem_r [0:DEPTH-1];
   logic              clr_we_s;
   logic [AWIDTH-1:0] clr_addr_s;
   logic              busy_s;
   logic              wr_ok_s;
   logic              oob_hit_s;
   logic              oob_err_r;
   logic [DWIDTH-1:0] iout_s;
   logic [DWIDTH-1:0] dout_s;

   // True when the address maps onto an implemented word
   function automatic logic in_range(input logic [AWIDTH-1:0] a);
      return ({1'b0, a} < DEPTH_W);
   endfunction

   mem_clear_ctrl #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .clr_we   (clr_we_s),
      .clr_addr (clr_addr_s),
      .busy     (busy_s)
   );

   assign wr_ok_s   = bus.wen && in_range(bus.waddr);
   assign oob_hit_s = (bus.wen && !in_range(bus.waddr)) ||
                      !in_range(bus.raddr_i) || !in_range(bus.raddr_d);

   // Array write mux: the sweep owns the array while busy; the rst edge itself writes nothing
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_we_s) begin
            mem_r[clr_addr_s] <= {DWIDTH{1'b0}};
         end else if (wr_ok_s) begin
            mem_r[bus.waddr] <= bus.din;
         end
      end
   end

   // Sticky range error: cleared only by rst, frozen during the sweep
   always_ff @(posedge clk) begin
      if (rst) begin
         oob_err_r <= 1'b0;
      end else if (!busy_s && oob_hit_s) begin
         oob_err_r <= 1'b1;
      end
   end

   // Read ports: zero while busy or out of range, bypass a same-cycle write, else the array
   always_comb begin
      iout_s = {DWIDTH{1'b0}};
      dout_s = {DWIDTH{1'b0}};
      if (busy_s) begin
         iout_s = {DWIDTH{1'b0}};
         dout_s = {DWIDTH{1'b0}};
      end else begin
         if (!in_range(bus.raddr_i)) begin
            iout_s = {DWIDTH{1'b0}};
         end else if (wr_ok_s && (bus.raddr_i == bus.waddr)) begin
            iout_s = bus.din;
         end else begin
            iout_s = mem_r[bus.raddr_i];
         end
         if (!in_range(bus.raddr_d)) begin
            dout_s = {DWIDTH{1'b0}};
         end else if (wr_ok_s && (bus.raddr_d == bus.waddr)) begin
            dout_s = bus.din;
         end else begin
            dout_s = mem_r[bus.raddr_d];
         end
      end
   end

   assign bus.iout    = iout_s;
   assign bus.dout    = dout_s;
   assign bus.busy    = busy_s;
   assign bus.oob_err = oob_err_r;

`ifdef MEM_DBG_WINDOW_EN
   // The window must lie entirely inside the implemented words
   if (DBG_BASE + DBG_WORDS > DEPTH) begin : g_dbg_range_bad
      $error("unified_mem_v2: debug window exceeds DEPTH");
   end

   // Window taps the stored array directly, so it never shows bypassed data
   for (genvar g = 0; g < DBG_WORDS; g++) begin : g_dbg
      assign bus.mem_out[g*DWIDTH +: DWIDTH] = mem_r[DBG_BASE + g];
   end
`else
   // Window parameters only matter when the window is built
   if ((DBG_BASE < 0) || (DBG_WORDS < 0)) begin : g_dbg_params_unused
   end
`endif

endmodule

// File: tb/tb_unified_mem_v2.sv
// tb_unified_mem_v2: randomized bench with a behavioural memory model and
// directed literal checks for sweep timing, bypass, dual-port reads and range errors.
module tb_unified_mem_v2;

   localparam int DW        = 16;
   localparam int AW        = 8;
   localparam int DEPTH     = 200;
   localparam int DBG_BASE  = 30;
   localparam int DBG_WORDS = 12;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   unified_mem_v2_if #(
      .DWIDTH(DW), .AWIDTH(AW)
`ifdef MEM_DBG_WINDOW_EN
      , .DBG_WORDS(DBG_WORDS)
`endif
   ) bus ();

   unified_mem_v2 #(
      .DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH),
      .DBG_BASE(DBG_BASE), .DBG_WORDS(DBG_WORDS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // behavioural model
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_oob       = 1'b0;
   int            busy_left   = 0;
   bit            state_known = 1'b0;
   bit            mem_known   = 1'b0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_read(input int a);
      if (busy_left > 0) return 16'h0000;
      if (a >= DEPTH) return 16'h0000;
      if (bus.wen && a == int'(bus.waddr)) return bus.din;
      return m_mem[a];
   endfunction

   function automatic logic [191:0] m_window();
      logic [191:0] w;
      w = '0;
      for (int i = 0; i < DBG_WORDS; i++) w[i*DW +: DW] = m_mem[DBG_BASE + i];
      return w;
   endfunction

   // Model: rst starts a DEPTH-edge sweep that ends with every word zero; writes/range errors only when idle
   always @(posedge clk) begin
      if (rst === 1'b1) begin
         state_known <= 1'b1;
         busy_left   <= DEPTH;
         m_oob       <= 1'b0;
      end else if (state_known) begin
         if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
               for (int i = 0; i < DEPTH; i++) m_mem[i] <= 16'h0000;
               mem_known <= 1'b1;
            end
         end else begin
            if (bus.wen && int'(bus.waddr) < DEPTH) m_mem[int'(bus.waddr)] <= bus.din;
            if ((bus.wen && int'(bus.waddr) >= DEPTH) ||
                int'(bus.raddr_i) >= DEPTH || int'(bus.raddr_d) >= DEPTH)
               m_oob <= 1'b1;
         end
      end
   end

   // Compare DUT outputs with the model every cycle once state is defined
   always @(negedge clk) begin
      if (state_known) begin
         chk("busy",    192'(bus.busy),    192'(busy_left > 0));
         chk("oob_err", 192'(bus.oob_err), 192'(m_oob));
         chk("iout",    192'(bus.iout),    192'(m_read(int'(bus.raddr_i))));
         chk("dout",    192'(bus.dout),    192'(m_read(int'(bus.raddr_d))));
`ifdef MEM_DBG_WINDOW_EN
         if (mem_known && busy_left == 0) chk("mem_out", bus.mem_out, m_window());
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input int wa, input logic [DW-1:0] d, input int ri, input int rd);
      bus.wen     = w;
      bus.waddr   = AW'(wa);
      bus.din     = d;
      bus.raddr_i = AW'(ri);
      bus.raddr_d = AW'(rd);
   endtask

   // Count edges from the rst edge (inclusive) to the edge on which busy falls
   task automatic sweep_edges(input string name);
      int n;
      n = 1;
      while (bus.busy === 1'b1 && n < 1000) begin
         step();
         n++;
      end
      chk(name, 192'(n), 192'(DEPTH + 1));
      if (bus.busy === 1'b1) begin
         $display("FAIL %s_timeout: busy still high after %0d edges", name, n);
         n_fail++;
      end
   endtask

   initial begin
      drive(1'b0, 0, 16'h0000, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;

      // sweep timing with a write attempted on every busy edge
      drive(1'b1, 7, 16'hDEAD, 7, 7);
      sweep_edges("sweep_edges");
      drive(1'b0, 0, 16'h0000, 0, 7);
      @(negedge clk);
      chk("busy_write_dropped", 192'(bus.dout), 192'(16'h0000));

      // every word reads zero after the sweep
      for (int a = 0; a < DEPTH; a++) begin
         step();
         drive(1'b0, 0, 16'h0000, a, DEPTH - 1 - a);
      end

      // write with same-cycle bypass on both ports
      step();
      drive(1'b1, 5, 16'hBEEF, 5, 5);
      @(negedge clk);
      chk("bypass_iout", 192'(bus.iout), 192'(16'hBEEF));
      chk("bypass_dout", 192'(bus.dout), 192'(16'hBEEF));
      step();
      drive(1'b0, 0, 16'h0000, 5, 5);
      @(negedge clk);
      chk("stored_iout", 192'(bus.iout), 192'(16'hBEEF));
      chk("stored_dout", 192'(bus.dout), 192'(16'hBEEF));

      // dual-port independence
      step();
      drive(1'b1, 10, 16'h1111, 0, 0);
      step();
      drive(1'b1, 11, 16'h2222, 0, 0);
      step();
      drive(1'b0, 0, 16'h0000, 10, 11);
      @(negedge clk);
      chk("dual_iout", 192'(bus.iout), 192'(16'h1111));
      chk("dual_dout", 192'(bus.dout), 192'(16'h2222));

      // random in-range traffic with frequent bypass hits
      for (int k = 0; k < 300; k++) begin
         int wa, ri, rd;
         step();
         wa = int'($urandom_range(0, DEPTH - 1));
         ri = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1));
         rd = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1));
         drive(1'($urandom_range(0, 1)), wa, 16'($urandom), ri, rd);
      end

`ifdef MEM_DBG_WINDOW_EN
      step();
      drive(1'b1, 30, 16'h00AA, 0, 0);
      step();
      drive(1'b1, 41, 16'h00BB, 0, 0);
      step();
      drive(1'b0, 0, 16'h0000, 0, 0);
      @(negedge clk);
      chk("win_lo", 192'(bus.mem_out[15:0]),    192'(16'h00AA));
      chk("win_hi", 192'(bus.mem_out[191:176]), 192'(16'h00BB));
`endif

      // out-of-range write and read
      step();
      drive(1'b1, 5, 16'hBEEF, 5, 5);
      @(negedge clk);
      chk("oob_before", 192'(bus.oob_err), 192'(1'b0));
      step();
      drive(1'b1, 250, 16'h1234, 5, 5);
      step();
      drive(1'b0, 0, 16'h0000, 5, 5);
      @(negedge clk);
      chk("oob_set",       192'(bus.oob_err), 192'(1'b1));
      chk("oob_no_change", 192'(bus.dout),    192'(16'hBEEF));
      step();
      drive(1'b0, 0, 16'h0000, 5, 210);
      @(negedge clk);
      chk("oob_read_zero", 192'(bus.dout), 192'(16'h0000));
      repeat (3) step();
      drive(1'b0, 0, 16'h0000, 5, 5);
      @(negedge clk);
      chk("oob_sticky", 192'(bus.oob_err), 192'(1'b1));

      // reset clears the flag, then restart the sweep mid-way
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_oob",  192'(bus.oob_err), 192'(1'b0));
      chk("rst_busy", 192'(bus.busy),    192'(1'b1));
      chk("rst_iout", 192'(bus.iout),    192'(16'h0000));
      repeat (49) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      sweep_edges("midsweep_edges");
      drive(1'b0, 0, 16'h0000, 10, 5);
      @(negedge clk);
      chk("cleared_iout", 192'(bus.iout), 192'(16'h0000));
      chk("cleared_dout", 192'(bus.dout), 192'(16'h0000));

      // random traffic including out-of-range addresses
      for (int k = 0; k < 200; k++) begin
         int wa, ri, rd;
         step();
         wa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEPTH, 255)) : int'($urandom_range(0, DEPTH - 1));
         ri = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, DEPTH - 1));
         rd = ($urandom_range(0, 9) == 0) ? int'($urandom_range(DEPTH, 255)) : int'($urandom_range(0, DEPTH - 1));
         drive(1'($urandom_range(0, 1)), wa, 16'($urandom), ri, rd);
      end

      step();
      drive(1'b0, 0, 16'h0000, 0, 0);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
